fuec_dec_result_stage: RTL and testbench

- Registered output stage directly downstream of the 48/32 FUEC decoder interface.
- Consumes the corrected data word and the 32-bit corrected-bit-position vector, and attaches the word's address.
- Presents results through a 2-entry valid/ready skid buffer, so downstream backpressure never stalls the combinational decoder path.
- Maintains saturating error statistics for scrubbing/telemetry software.

---
 rtl/fuec_dec_result_stage_if.sv | 30 +++
 rtl/fuec_dec_result_stage.sv | 149 ++++++++++++++
 tb/tb_fuec_dec_result_stage.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fuec_dec_result_stage_if.sv
// Handshake/bus bundle between the FUEC decoder side, the result stage and
// the downstream consumer. The master drives words in and accepts results;
// the slave is the result stage itself.
interface fuec_dec_result_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int NF_W   = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] in_pos_error;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              out_err;
    logic [NF_W-1:0]   out_nflips;

    modport master (
        output in_valid, in_addr, in_data, in_pos_error, out_ready,
        input  in_ready, out_valid, out_addr, out_data, out_err, out_nflips
    );

    modport slave (
        input  in_valid, in_addr, in_data, in_pos_error, out_ready,
        output in_ready, out_valid, out_addr, out_data, out_err, out_nflips
    );
endinterface

// File: rtl/fuec_dec_result_stage.sv
// Registered result stage behind the 48/32 FUEC decoder: tags each corrected
// word with its address, counts its flipped bits, queues it in a 2-entry skid
// buffer and keeps saturating error statistics.
// Optional: define FUEC_ERR_LOG_EN to add a latest-error log (log_valid,
// log_addr, log_pos).
module fuec_dec_result_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16,
    parameter int NF_W   = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    fuec_dec_result_stage_if.slave bus,
    input  logic                 clr_stats,
    output logic [CNT_W-1:0]     err_word_cnt,
    output logic [CNT_W-1:0]     err_bit_cnt,
    output logic                 stats_sat
`ifdef FUEC_ERR_LOG_EN
    ,
    output logic                 log_valid,
    output logic [ADDR_W-1:0]    log_addr,
    output logic [DATA_W-1:0]    log_pos
`endif
);
    // Sum width wide enough for counter plus a full-word popcount.
    localparam int SW = ((CNT_W > NF_W) ? CNT_W : NF_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]             cnt_q, cnt_d;
    logic                   head_q, tail_q;
    logic                   in_ready_q;
    logic [1:0][ADDR_W-1:0] addr_q;
    logic [1:0][DATA_W-1:0] data_q;
    logic [1:0]             err_q;
    logic [1:0][NF_W-1:0]   nf_q;
    logic [CNT_W-1:0]       word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   sat_q;
    logic [NF_W-1:0]        popcnt;
    logic                   in_err;
    logic [SW-1:0]          bit_sum;
    logic                   push, pop;

    assign push = bus.in_valid & in_ready_q;
    assign pop  = bus.out_valid & bus.out_ready;
    assign in_err = |bus.in_pos_error;

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = (cnt_q != 2'd0);
    assign bus.out_addr   = addr_q[head_q];
    assign bus.out_data   = data_q[head_q];
    assign bus.out_err    = err_q[head_q];
    assign bus.out_nflips = nf_q[head_q];

    assign err_word_cnt = word_cnt_q;
    assign err_bit_cnt  = bit_cnt_q;
    assign stats_sat    = sat_q;

    // Popcount of the input correction mask, occupancy and saturating stats next-state.
    always_comb begin
        popcnt = '0;
        for (int i = 0; i < DATA_W; i++) popcnt = popcnt + NF_W'(bus.in_pos_error[i]);
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 2'd1;
        else if (!push && pop) cnt_d = cnt_q - 2'd1;
        bit_sum    = SW'(bit_cnt_q) + SW'(popcnt);
        word_cnt_d = word_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (push) begin
            if (in_err && word_cnt_q != CNT_MAX) word_cnt_d = word_cnt_q + 1'b1;
            bit_cnt_d = (bit_sum > SW'(CNT_MAX)) ? CNT_MAX : bit_sum[CNT_W-1:0];
        end
    end

    // Occupancy, ring pointers and registered in_ready (from next occupancy).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            in_ready_q <= (cnt_d < 2'd2);
            if (push) tail_q <= ~tail_q;
            if (pop)  head_q <= ~head_q;
        end
    end

    // Entry storage written at the tail on accept; flags computed on the input side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            data_q <= '0;
            err_q  <= '0;
            nf_q   <= '0;
        end else if (push) begin
            addr_q[tail_q] <= bus.in_addr;
            data_q[tail_q] <= bus.in_data;
            err_q[tail_q]  <= in_err;
            nf_q[tail_q]   <= popcnt;
        end
    end

    // Saturating statistics; a clear in the same cycle beats any accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt_q <= '0;
            bit_cnt_q  <= '0;
            sat_q      <= 1'b0;
        end else if (clr_stats) begin
            word_cnt_q <= '0;
            bit_cnt_q  <= '0;
            sat_q      <= 1'b0;
        end else begin
            word_cnt_q <= word_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sat_q      <= sat_q | (word_cnt_d == CNT_MAX) | (bit_cnt_d == CNT_MAX);
        end
    end

`ifdef FUEC_ERR_LOG_EN
    logic              log_valid_q;
    logic [ADDR_W-1:0] log_addr_q;
    logic [DATA_W-1:0] log_pos_q;

    assign log_valid = log_valid_q;
    assign log_addr  = log_addr_q;
    assign log_pos   = log_pos_q;

    // Latest-error capture for scrubbing software; clear beats capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            log_valid_q <= 1'b0;
            log_addr_q  <= '0;
            log_pos_q   <= '0;
        end else if (clr_stats) begin
            log_valid_q <= 1'b0;
            log_addr_q  <= '0;
            log_pos_q   <= '0;
        end else if (push && in_err) begin
            log_valid_q <= 1'b1;
            log_addr_q  <= bus.in_addr;
            log_pos_q   <= bus.in_pos_error;
        end
    end
`endif
endmodule

// File: tb/tb_fuec_dec_result_stage.sv
// Directed bench for fuec_dec_result_stage: a default-size instance plus a
// CNT_W=4 instance for counter saturation.
module tb_fuec_dec_result_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic clr2 = 1'b0;
    logic [15:0] wcnt, bcnt;
    logic [3:0]  wcnt2, bcnt2;
    logic        sat, sat2;
    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    fuec_dec_result_stage_if #(.DATA_W(32), .ADDR_W(10), .NF_W(6)) bus ();
    fuec_dec_result_stage_if #(.DATA_W(32), .ADDR_W(10), .NF_W(6)) bus2 ();

`ifdef FUEC_ERR_LOG_EN
    logic        lv, lv2;
    logic [9:0]  la, la2;
    logic [31:0] lp, lp2;
`endif

    fuec_dec_result_stage #(.DATA_W(32), .ADDR_W(10), .CNT_W(16), .NF_W(6)) dut (
        .clk(clk), .rst(rst), .bus(bus), .clr_stats(clr),
        .err_word_cnt(wcnt), .err_bit_cnt(bcnt), .stats_sat(sat)
`ifdef FUEC_ERR_LOG_EN
        , .log_valid(lv), .log_addr(la), .log_pos(lp)
`endif
    );

    fuec_dec_result_stage #(.DATA_W(32), .ADDR_W(10), .CNT_W(4), .NF_W(6)) dut_sat (
        .clk(clk), .rst(rst), .bus(bus2), .clr_stats(clr2),
        .err_word_cnt(wcnt2), .err_bit_cnt(bcnt2), .stats_sat(sat2)
`ifdef FUEC_ERR_LOG_EN
        , .log_valid(lv2), .log_addr(la2), .log_pos(lp2)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [9:0] a, input logic [31:0] d, input logic [31:0] p);
        bus.in_valid = v; bus.in_addr = a; bus.in_data = d; bus.in_pos_error = p;
    endtask

    task automatic test_reset();
        drive(1'b0, '0, '0, '0);
        bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_addr = '0; bus2.in_data = '0; bus2.in_pos_error = '0;
        bus2.out_ready = 1'b1;
        step(); step();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_out_nflips", 64'(bus.out_nflips), 64'd0);
        chk("rst_cnts", {32'(wcnt), 32'(bcnt)}, 64'd0);
        chk("rst_sat", 64'(sat), 64'd0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready_pre_edge", 64'(bus.in_ready), 64'd0);
        step();
        chk("rel_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rel_out_valid", 64'(bus.out_valid), 64'd0);
    endtask

    task automatic test_passthrough();
        bus.out_ready = 1'b1;
        drive(1'b1, 10'h005, 32'hDEADBEEF, 32'h0);
        step();
        drive(1'b0, '0, '0, '0);
        chk("pt_out_valid", 64'(bus.out_valid), 64'd1);
        chk("pt_out_data", 64'(bus.out_data), 64'hDEADBEEF);
        chk("pt_out_addr", 64'(bus.out_addr), 64'h5);
        chk("pt_out_err", 64'(bus.out_err), 64'd0);
        chk("pt_out_nflips", 64'(bus.out_nflips), 64'd0);
        chk("pt_cnts", {32'(wcnt), 32'(bcnt)}, 64'd0);
        step();
        chk("pt_drained", 64'(bus.out_valid), 64'd0);
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(1'b1, 10'h001, 32'h11111111, 32'h80000003);
        step();
        chk("bp_in_ready_1", 64'(bus.in_ready), 64'd1);
        drive(1'b1, 10'h002, 32'h22222222, 32'h0);
        step();
        drive(1'b1, 10'h003, 32'h33333333, 32'hFFFFFFFF);
        chk("bp_in_ready_full", 64'(bus.in_ready), 64'd0);
        chk("bp_word_cnt", 64'(wcnt), 64'd1);
        chk("bp_bit_cnt", 64'(bcnt), 64'd3);
        chk("bp_head_data", 64'(bus.out_data), 64'h11111111);
        chk("bp_head_nflips", 64'(bus.out_nflips), 64'd3);
        step();
        drive(1'b0, '0, '0, '0);
        chk("bp_hold_data", 64'(bus.out_data), 64'h11111111);
        chk("bp_hold_addr", 64'(bus.out_addr), 64'h1);
        chk("bp_ignored_cnt", 64'(bcnt), 64'd3);
        bus.out_ready = 1'b1;
        step();
        chk("bp_second_data", 64'(bus.out_data), 64'h22222222);
        chk("bp_second_err", 64'(bus.out_err), 64'd0);
        chk("bp_in_ready_back", 64'(bus.in_ready), 64'd1);
        step();
        chk("bp_empty", 64'(bus.out_valid), 64'd0);
    endtask

    task automatic test_stream();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_cnts", {32'(wcnt), 32'(bcnt)}, 64'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 10'(i + 16), 32'(i + 32'h100), 32'h1);
            step();
            chk("st_valid", 64'(bus.out_valid), 64'd1);
            chk("st_data", 64'(bus.out_data), 64'(i + 32'h100));
            chk("st_in_ready", 64'(bus.in_ready), 64'd1);
        end
        drive(1'b0, '0, '0, '0);
        step();
        chk("st_drained", 64'(bus.out_valid), 64'd0);
        chk("st_word_cnt", 64'(wcnt), 64'd8);
        chk("st_bit_cnt", 64'(bcnt), 64'd8);
    endtask

    task automatic test_clear_same_cycle();
        drive(1'b1, 10'h0AB, 32'h0000ABCD, 32'hF);
        clr = 1'b1;
        step();
        clr = 1'b0;
        drive(1'b0, '0, '0, '0);
        chk("cl_cnts", {32'(wcnt), 32'(bcnt)}, 64'd0);
        chk("cl_out_data", 64'(bus.out_data), 64'hABCD);
        chk("cl_out_nflips", 64'(bus.out_nflips), 64'd4);
        chk("cl_out_err", 64'(bus.out_err), 64'd1);
        step();
    endtask

    task automatic test_saturation();
        bus2.in_valid = 1'b1; bus2.in_pos_error = 32'h00003FFF;
        step();
        chk("sat_bit_14", 64'(bcnt2), 64'd14);
        chk("sat_flag_0", 64'(sat2), 64'd0);
        bus2.in_pos_error = 32'h7;
        step();
        chk("sat_bit_15", 64'(bcnt2), 64'd15);
        chk("sat_flag_1", 64'(sat2), 64'd1);
        chk("sat_word_2", 64'(wcnt2), 64'd2);
        bus2.in_pos_error = 32'hFFFFFFFF;
        step();
        bus2.in_valid = 1'b0;
        chk("sat_bit_hold", 64'(bcnt2), 64'd15);
        chk("sat_nflips_32", 64'(bus2.out_nflips), 64'd32);
        chk("sat_word_3", 64'(wcnt2), 64'd3);
    endtask

    task automatic test_reset_midflight();
        bus.out_ready = 1'b0;
        drive(1'b1, 10'h00A, 32'hAAAA0000, 32'h1);
        step(); step();
        drive(1'b0, '0, '0, '0);
        chk("mr_full", 64'(bus.in_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("mr_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mr_in_ready", 64'(bus.in_ready), 64'd0);
        step();
        rst = 1'b0;
        step();
        chk("mr_in_ready_rel", 64'(bus.in_ready), 64'd1);
        chk("mr_out_data", 64'(bus.out_data), 64'd0);
        chk("mr_cnts", {32'(wcnt), 32'(bcnt)}, 64'd0);
    endtask

`ifdef FUEC_ERR_LOG_EN
    task automatic test_err_log();
        bus.out_ready = 1'b1;
        chk("log_rst_valid", 64'(lv), 64'd0);
        drive(1'b1, 10'h010, 32'h1, 32'h1);
        step();
        drive(1'b1, 10'h020, 32'h2, 32'h2);
        step();
        drive(1'b1, 10'h030, 32'h3, 32'h0);
        step();
        drive(1'b0, '0, '0, '0);
        chk("log_valid", 64'(lv), 64'd1);
        chk("log_addr", 64'(la), 64'h20);
        chk("log_pos", 64'(lp), 64'h2);
        drive(1'b1, 10'h040, 32'h4, 32'h8);
        clr = 1'b1;
        step();
        clr = 1'b0;
        drive(1'b0, '0, '0, '0);
        chk("log_clr_valid", 64'(lv), 64'd0);
        chk("log_clr_addr", 64'(la), 64'h0);
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_passthrough();
        test_backpressure();
        test_stream();
        test_clear_same_cycle();
        test_saturation();
        test_reset_midflight();
`ifdef FUEC_ERR_LOG_EN
        test_err_log();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
